// File: rtl/onehot_decoder.sv
// Registered binary-to-one-hot decoder behind a two-entry (output + skid)
// valid/ready buffer, with a saturating count of out-of-range indices.
module onehot_decoder #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = $clog2(WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [IDX_WIDTH-1:0] i_idx,
  input  logic                 i_en,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_onehot,
  output logic                 o_err,
  output logic [7:0]           o_err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_n;
  logic             ready_q;
  logic [WIDTH-1:0] out_q, skid_q, dec;
  logic             out_err_q, skid_err_q, dec_err;
  logic [7:0]       err_cnt_q;
  logic [31:0]      idx_ext;
  logic             accept, deliver;
  logic             load_out, load_skid, shift, clear_out;

  // Compare in 32 bits so non-power-of-two WIDTH sees the full index range.
  assign idx_ext = 32'(i_idx);

  always_comb begin
    dec = '0;
    for (int b = 0; b < WIDTH; b++) dec[b] = i_en && (idx_ext == 32'(b));
    dec_err = (idx_ext >= 32'(WIDTH));
  end

  assign accept  = i_valid && ready_q;
  assign deliver = (state != EMPTY) && i_ready;

  always_comb begin
    state_n   = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    clear_out = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_n  = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (accept && deliver) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_n   = EMPTY;
          clear_out = 1'b1;
        end
      end
      TWO: if (deliver) begin
        state_n = ONE;
        shift   = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
  end

  // ready is registered from next state so it never sees i_valid/i_ready combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != TWO);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q      <= '0;
      out_err_q  <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (load_out) begin
        out_q     <= dec;
        out_err_q <= dec_err;
      end else if (shift) begin
        out_q     <= skid_q;
        out_err_q <= skid_err_q;
      end else if (clear_out) begin
        out_q     <= '0;
        out_err_q <= 1'b0;
      end
      if (load_skid) begin
        skid_q     <= dec;
        skid_err_q <= dec_err;
      end else if (shift) begin
        skid_q     <= '0;
        skid_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   err_cnt_q <= '0;
    else if (accept && dec_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign o_ready   = ready_q;
  assign o_valid   = (state != EMPTY);
  assign o_onehot  = out_q;
  assign o_err     = out_err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Drives WIDTH=8 and WIDTH=6 decoders with identical stimulus and checks both
// against a queue-based reference of the valid/ready behaviour.
module tb_onehot_decoder;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0, i_en = 1'b0, i_ready = 1'b0;
  logic [2:0] i_idx = '0;
  logic       o_ready8, o_valid8, o_err8, o_ready6, o_valid6, o_err6;
  logic [7:0] o_onehot8, o_err_cnt8, o_err_cnt6;
  logic [5:0] o_onehot6;

  always #5 i_clk = ~i_clk;

  onehot_decoder #(.WIDTH(8)) u8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready8),
    .i_idx(i_idx), .i_en(i_en), .o_valid(o_valid8), .i_ready(i_ready),
    .o_onehot(o_onehot8), .o_err(o_err8), .o_err_cnt(o_err_cnt8));

  onehot_decoder #(.WIDTH(6)) u6 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready6),
    .i_idx(i_idx), .i_en(i_en), .o_valid(o_valid6), .i_ready(i_ready),
    .o_onehot(o_onehot6), .o_err(o_err6), .o_err_cnt(o_err_cnt6));

  typedef struct packed {
    logic [7:0] oh;
    logic       err;
  } beat_t;

  beat_t q8[$], q6[$];
  int    n, cnt8, cnt6;
  logic  rdy;
  int    checks = 0, errors = 0;

  function automatic beat_t ref_beat(input int w, input int idx, input bit en);
    beat_t b;
    b.oh  = (en && idx < w) ? 8'(1 << idx) : 8'h00;
    b.err = (idx >= w);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready8", o_ready8, rdy);
    chk("ready6", o_ready6, rdy);
    chk("valid8", o_valid8, n > 0);
    chk("valid6", o_valid6, n > 0);
    if (n > 0) begin
      chk("onehot8", o_onehot8, q8[0].oh);
      chk("onehot6", o_onehot6, q6[0].oh);
      chk("err8", o_err8, q8[0].err);
      chk("err6", o_err6, q6[0].err);
    end else begin
      chk("onehot8_idle", o_onehot8, 0);
      chk("onehot6_idle", o_onehot6, 0);
    end
    chk("errcnt8", o_err_cnt8, cnt8);
    chk("errcnt6", o_err_cnt6, cnt6);
  endtask

  // Called just after a falling edge; outputs are checked at the next falling edge.
  task automatic step(input bit v, input int idx, input bit en, input bit r);
    bit acc, del;
    i_valid = v;
    i_idx   = 3'(idx);
    i_en    = en;
    i_ready = r;
    @(posedge i_clk);
    acc = v && rdy;
    del = (n > 0) && r;
    if (del) begin
      void'(q8.pop_front());
      void'(q6.pop_front());
      n--;
    end
    if (acc) begin
      q8.push_back(ref_beat(8, idx, en));
      q6.push_back(ref_beat(6, idx, en));
      n++;
      if (idx >= 8) cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
      if (idx >= 6) cnt6 = (cnt6 < 255) ? cnt6 + 1 : 255;
    end
    rdy = (n < 2);
    @(negedge i_clk);
    check_all();
  endtask

  task automatic pulse_reset();
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_ready8", o_ready8, 0);
    chk("rst_ready6", o_ready6, 0);
    chk("rst_valid8", o_valid8, 0);
    chk("rst_valid6", o_valid6, 0);
    chk("rst_onehot8", o_onehot8, 0);
    chk("rst_onehot6", o_onehot6, 0);
    chk("rst_errcnt6", o_err_cnt6, 0);
    q8.delete();
    q6.delete();
    n = 0; cnt8 = 0; cnt6 = 0; rdy = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    n = 0; cnt8 = 0; cnt6 = 0; rdy = 1'b0;
    @(negedge i_clk);
    pulse_reset();
    // valid is high on the first edge after release but ready is still low
    step(1, 4, 1, 1);
    step(0, 0, 0, 1);

    step(1, 5, 1, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 8; i++) step(1, i, 1, 1);
    step(0, 0, 0, 1);

    step(1, 1, 1, 0);
    step(1, 2, 1, 0);
    step(1, 3, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    step(1, 3, 0, 1);
    step(0, 0, 0, 1);

    step(1, 7, 1, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 7, 1, 1);
    step(0, 0, 0, 1);
    chk("errcnt6_sat", o_err_cnt6, 255);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    step(1, 1, 1, 0);
    step(1, 6, 1, 0);
    chk("two_ready8", o_ready8, 0);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, $urandom_range(0, 7), 1, 1);
    step(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of one-hot output bits; legal range 2..256.
REQ-002 SHALL have parameter IDX_WIDTH, default $clog2(WIDTH), index width in bits.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_valid  input  1  upstream index valid.
REQ-006 SHALL have port o_ready  output  1  decoder can accept an index.
REQ-007 SHALL have port i_idx  input  IDX_WIDTH  binary index to decode.
REQ-008 SHALL have port i_en  input  1  sampled with i_idx; 0 forces an all-zero output word.
REQ-009 SHALL have port o_valid  output  1  output word valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts output word.
REQ-011 SHALL have port o_onehot  output  WIDTH  decoded word.
REQ-012 SHALL have port o_err  output  1  qualifies o_onehot; set when the captured i_idx >= WIDTH.
REQ-013 SHALL have port o_err_cnt  output  8  saturating count of accepted out-of-range indices.

Function
REQ-014 SHALL accept an input beat on a rising edge where i_valid && o_ready; SHALL deliver an output beat on a rising edge where o_valid && i_ready.
REQ-015 SHALL compute decoded word = i_en && i_idx < WIDTH ? (1 << i_idx) : 0, zero-extended to WIDTH; err = i_idx >= WIDTH regardless of i_en.
REQ-016 SHALL register the result: an accepted beat appears on o_onehot/o_err with o_valid=1 exactly one cycle after acceptance when the output stage is empty or draining.
REQ-017 SHALL implement a two-entry buffer (output register plus skid register); states EMPTY (0 held), ONE (output register full), TWO (both full).
REQ-018 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-019 ONE: accept && deliver -> ONE with output register replaced; accept only -> TWO (new beat into skid); deliver only -> EMPTY; neither -> ONE.
REQ-020 TWO: deliver -> ONE with skid moved into output register; no deliver -> TWO; no accept possible.
REQ-021 o_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in TWO; SHALL not depend combinationally on i_ready or i_valid.
REQ-022 o_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; o_onehot/o_err SHALL be stable while o_valid && !i_ready.
REQ-023 o_onehot SHALL be all zero whenever o_valid=0.
REQ-024 Order SHALL be preserved; no beat dropped or duplicated under any i_valid/i_ready pattern.
REQ-025 o_err_cnt SHALL increment by 1 on each accepted beat with i_idx >= WIDTH, saturating at 255; counts at acceptance, not delivery.
REQ-026 With WIDTH a power of two, o_err and o_err_cnt SHALL remain 0.
REQ-027 Throughput SHALL be one beat per cycle with i_valid and i_ready held high.

Reset
REQ-028 On i_rst_n=0, asynchronously: state EMPTY, o_valid=0, o_ready=0, o_onehot=0, o_err=0, o_err_cnt=0, skid cleared.
REQ-029 o_ready SHALL rise on the first rising edge after i_rst_n deasserts; no beat accepted during reset.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered beats; none delivered after reset.

Verification
REQ-031 WIDTH=8, i_idx=5, i_en=1, i_ready=1 -> next cycle o_valid=1, o_onehot=8'b0010_0000, o_err=0.
REQ-032 WIDTH=8, stream idx 0..7 back-to-back, i_ready=1 -> 8 consecutive beats 0x01,0x02,...,0x80, o_ready always 1.
REQ-033 i_ready=0, send idx 1,2 -> o_ready=0 after second accept, o_onehot=0x02 held; raise i_ready -> 0x02 then 0x04, o_ready=1 again.
REQ-034 WIDTH=6, i_idx=7, i_en=1 -> o_onehot=6'b0, o_err=1, o_err_cnt=1; 300 such beats -> o_err_cnt=255.
REQ-035 i_en=0, i_idx=3 -> o_valid=1, o_onehot=0, o_err=0.
REQ-036 State TWO, pulse i_rst_n low -> o_valid=0, o_onehot=0, o_err_cnt=0 immediately; no stale beat after release.
